// File: rtl/bch_checker.sv
// Serial BCH(255,191) codeword checker. A 64-bit division LFSR consumes the
// word MSB-first, then the remainder, error flag and message are handed off.
module bch_checker #(
  parameter int              N = 255,
  parameter int              K = 191,
  parameter logic [N-K-1:0]  G = 64'h6CE7_07E2_6B6F_9977
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_cw,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [K-1:0]   out_msg,
  output logic [N-K-1:0] out_rem,
  output logic           out_err,
  output logic [15:0]    err_cnt
);

  localparam int R = N - K;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   sr_q, sr_d;
  logic [R-1:0]   lfsr_q, lfsr_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;
  logic [R-1:0]   out_rem_q, out_rem_d;
  logic           out_err_q, out_err_d;
  logic [15:0]    err_cnt_q, err_cnt_d;

  logic           fb;
  logic [R-1:0]   lfsr_step;

  // The word stays unshifted in sr_q; cnt_q selects the bit under division,
  // so the message field is available as-is for out_msg.
  always_comb begin
    fb        = lfsr_q[R-1] ^ sr_q[cnt_q];
    lfsr_step = {lfsr_q[R-2:0], 1'b0} ^ ({R{fb}} & G);
  end

  // NOTE: every variable gets a default before the case; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    lfsr_d    = lfsr_q;
    cnt_d     = cnt_q;
    out_rem_d = out_rem_q;
    out_err_d = out_err_q;
    err_cnt_d = err_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          sr_d    = in_cw;
          lfsr_d  = '0;
          cnt_d   = 8'(N - 1);
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        lfsr_d = lfsr_step;
        if (cnt_q == 8'd0) begin
          out_rem_d = lfsr_step;
          out_err_d = |lfsr_step;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      DONE: begin
        if (out_ready) begin
          if (out_err_q && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
          end
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      lfsr_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_rem_q   <= '0;
      out_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      lfsr_q      <= lfsr_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_rem_q   <= out_rem_d;
      out_err_q   <= out_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_msg   = sr_q[N-1:R];
  assign out_rem   = out_rem_q;
  assign out_err   = out_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: doc/bch_checker.md
# bch_checker

Serial BCH(255,191) codeword checker that sits directly downstream of the BCH encoder, or at the receive side of the channel model. It accepts a 255-bit codeword through a valid/ready handshake and shifts it MSB-first through a 64-bit division LFSR built on the same generator polynomial as the encoder. It then presents the 64-bit remainder, an error flag and the extracted 191-bit message through a second valid/ready handshake. A saturating counter tallies the number of erroneous words.

## Interface
- N, 255, codeword length
- K, 191, message length; remainder width is N-K = 64
- G, 64'h6CE707E26B6F9977, generator coefficients g[63:0] for x^63..x^0; the x^64 term is implicit, and g[0] must be 1
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  reset; synchronous and active-low
- in_valid  input  1  in_cw is valid
- in_ready  output  1  block can accept a word
- in_cw  input  N  codeword; bits [N-1:K'] hold the message (msg bit i at cw bit i+64), bits [63:0] hold the parity
- out_valid  output  1  result is valid
- out_ready  input  1  consumer accepts the result
- out_msg  output  K  in_cw[254:64] of the checked word
- out_rem  output  64  final LFSR remainder
- out_err  output  1  set when out_rem != 0
- err_cnt  output  16  count of erroneous words delivered; saturates at 16'hFFFF

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE**
  - in_ready = 1.
  - On in_valid & in_ready: capture in_cw into the shift register, clear the LFSR, set bit index cnt = 254, and go to SHIFT.
- **SHIFT**, one bit per cycle, processing b = cw[cnt]:
  - fb = D[63] ^ b
  - D[t] <= (fb & G[t]) ^ D[t-1], for t = 63..1
  - D[0] <= fb
  - If cnt == 0, go to DONE (out_rem <= the next D, out_err <= |next D); otherwise decrement cnt.
- **DONE**
  - out_valid = 1. out_msg, out_rem and out_err are held stable.
  - On out_valid & out_ready: if out_err is set and err_cnt != 16'hFFFF, increment err_cnt. Go to IDLE.
- Correctness rule: the remainder is zero if and only if the codeword is divisible by g(x). The LFSR computes cw(x)·x^64 mod g, and g(0) = 1.
- in_valid is ignored outside IDLE. No word is ever dropped silently, because in_ready is low outside IDLE.
- All arithmetic is GF(2). cnt is 8 bits wide.

## Timing
- Reset (rst = 0 at a clk edge):
  - state = IDLE, in_ready = 1, out_valid = 0.
  - out_msg, out_rem, out_err, err_cnt, the LFSR and cnt are all cleared to 0.
- A reset during SHIFT or DONE aborts the word. The word is discarded and err_cnt is cleared.
- in_ready is registered as (state == IDLE). It falls in the cycle after acceptance.
- Latency: the word is accepted at edge T. Bits are processed at edges T+1 through T+255. out_valid is high from the cycle after edge T+255.
- out_valid stays high with stable outputs until out_ready is sampled high. Backpressure of any length is allowed.
- After the output handshake at edge U, in_ready is high in the following cycle. The next word can be accepted at edge U+1.
- Minimum spacing between accepted words is 257 cycles.
- out_ready is ignored while out_valid = 0.

## Test plan
- **Reset values:** hold rst=0 for 3 cycles, then release. Expect in_ready=1, out_valid=0, err_cnt=0, out_rem=0.
- **All-zero word:** in_cw=0 with out_ready=1. Expect out_valid exactly 255 cycles after acceptance, out_rem=0, out_err=0, err_cnt=0.
- **Clean codeword:** encode msg=191'h1 with bch_encoder and feed the codeword. Expect out_rem=0, out_err=0, and out_msg=191'h1. Repeat for 20 random encoded messages; all must be error-free.
- **Single-bit error:** in_cw = 255'h1 (only parity bit 0 set). Expect out_rem=64'h6CE707E26B6F9977 and out_err=1; err_cnt goes 0→1 on the output handshake. Flipping any single bit of a valid codeword must give out_err=1.
- **Backpressure:** hold out_ready=0 for 10 cycles in DONE. Outputs must stay stable and in_ready=0, and in_valid pulses must be ignored. Then assert out_ready; in_ready=1 on the next cycle.
- **Reset mid-shift:** accept an erroneous word and drive rst=0 at the 100th SHIFT cycle. Expect IDLE next cycle, out_valid never asserted for that word, and err_cnt=0. A subsequent clean word must check with out_err=0.
